mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch and a
// data requester. Data wins contention, but after MAX_D consecutive data
// grants with a fetch waiting the fetch side is served. Each access is
// bounded by a TO_CYC-cycle wait timeout that completes it with err.
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MAX_D  = 4,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_f,
  output logic          stall_m
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] MAXD_C  = 4'(MAX_D);
  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  state_t        state_q;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [7:0]    wait_q, wait_d;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic          if_ready_q, d_ready_q, err_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic pick_d, pick_i, grant_d, grant_i;
  logic busy, timeout, done;

  // Arbitration picks a winner from the raw requests; the winner is only
  // granted if it is not in its own ready cycle, so a held request that was
  // just served is not mistaken for a fresh one and does not hand the slot
  // to the other side early.
  always_comb begin
    pick_d  = d_req & (~if_req | (dcnt_q != MAXD_C));
    pick_i  = if_req & ~pick_d;
    grant_d = (state_q == IDLE) & pick_d & ~d_ready_q;
    grant_i = (state_q == IDLE) & pick_i & ~if_ready_q;
    busy    = (state_q != IDLE);
    timeout = busy & ~mem_ready & (wait_q == TO_LAST);
    done    = busy & (mem_ready | timeout);
    wait_d  = busy ? (wait_q + 8'd1) : 8'd0;
    dcnt_d  = dcnt_q;
    if (grant_i) begin
      dcnt_d = 4'd0;
    end else if (grant_d) begin
      if (!if_req) begin
        dcnt_d = 4'd0;
      end else if (dcnt_q != MAXD_C) begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end
  end

  // Arbiter FSM: grant, hold the access until memory answers or the wait
  // counter expires, then pulse the matching ready for one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      dcnt_q     <= 4'd0;
      wait_q     <= 8'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
      dcnt_q     <= dcnt_d;
      wait_q     <= wait_d;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            state_q <= BUSY_D;
          end else if (grant_i) begin
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            state_q <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (done) begin
            state_q    <= IDLE;
            if_ready_q <= 1'b1;
            err_q      <= timeout;
            if_rdata_q <= timeout ? '0 : mem_rdata;
          end
        end
        BUSY_D: begin
          if (done) begin
            state_q   <= IDLE;
            d_ready_q <= 1'b1;
            err_q     <= timeout;
            d_rdata_q <= (timeout | we_q) ? '0 : mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid = busy;
  assign mem_we    = (state_q == BUSY_D) & we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall_f   = if_req & ~if_ready_q;
  assign stall_m   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transactions, expected responses
// queued by the stimulus and consumed by an independent ready monitor.
module tb_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MAX_D  = 4;
  localparam int TO_CYC = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall_f;
  logic          stall_m;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_D(MAX_D), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    mem_lat  = 0;   // wait cycles before mem_ready; negative = never
  bit    stray    = 1'b0; // drive mem_ready while no access is active

  // Memory contents: address 0x10 holds a fixed opcode, the rest is a tag.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hE3A0_0007;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] rdata, input bit e);
    resp_t r;
    r.is_d  = is_d;
    r.rdata = rdata;
    r.err   = e;
    exp_q.push_back(r);
  endtask

  // Memory responder
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1) begin
        busy_cnt++;
        if (mem_lat >= 0 && busy_cnt > mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        busy_cnt  = 0;
        mem_ready = stray;
        mem_rdata = 32'h5555_AAAA;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest queued expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (if_ready === 1'b1 || d_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ready: got if_ready=%0b d_ready=%0b, expected no pulse",
                   if_ready, d_ready);
        end else begin
          e = exp_q.pop_front();
          check("resp_kind_is_d", 32'(d_ready), 32'(e.is_d));
          check("resp_rdata", d_ready ? d_rdata : if_rdata, e.rdata);
          check("resp_err", 32'(err), 32'(e.err));
        end
      end else if (err === 1'b1) begin
        n_checks++;
        $display("FAIL err_without_ready: got err=1, expected 0");
      end
    end
  end

  // One isolated transaction: raise the request, check the memory-side
  // attributes, stall behaviour and latency, then drop it in the ready cycle.
  task automatic run_xact(input bit is_d, input logic [31:0] addr, input bit we,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input bit exp_err, input int exp_lat, input string tag);
    int n;
    bit stall_bad;
    bit got;
    push_exp(is_d, exp_rdata, exp_err);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0; stall_bad = 1'b0; got = 1'b0;
    while (!got && n < 400) begin
      tick();
      n++;
      if (n == 1) begin
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
        check({tag, "_mem_addr"}, mem_addr, addr);
        check({tag, "_mem_we"}, 32'(mem_we), 32'(is_d & we));
        check({tag, "_mem_wdata"}, mem_wdata, is_d ? wdata : 32'd0);
      end
      if ((is_d ? d_ready : if_ready) === 1'b1) got = 1'b1;
      else if ((is_d ? stall_m : stall_f) !== 1'b1) stall_bad = 1'b1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_stall_wait"}, 32'(stall_bad), 32'd0);
    check({tag, "_stall_ready"}, 32'(is_d ? stall_m : stall_f), 32'd0);
    if (is_d) d_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    int n;
    int cyc;
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b1;
    tick();

    // Single fetch, memory answers in the first busy cycle
    mem_lat = 0;
    run_xact(1'b0, 32'h10, 1'b0, 32'd0, 32'hE3A0_0007, 1'b0, 2, "fetch");

    // Stray mem_ready while idle must be ignored; fetch data is held
    stray = 1'b1;
    repeat (3) tick();
    check("stray_mem_valid", 32'(mem_valid), 32'd0);
    check("hold_if_rdata", if_rdata, 32'hE3A0_0007);
    stray = 1'b0;
    tick();

    // Store returns zero data; load returns memory data
    run_xact(1'b1, 32'h64, 1'b1, 32'd7, 32'd0, 1'b0, 2, "store");
    tick();
    run_xact(1'b1, 32'h80, 1'b0, 32'hFFFF_FFFF, 32'hC0DE_0080, 1'b0, 2, "load");
    tick();

    // Three-cycle memory wait on each side
    mem_lat = 3;
    run_xact(1'b1, 32'h90, 1'b0, 32'd0, 32'hC0DE_0090, 1'b0, 5, "load_wait");
    tick();
    run_xact(1'b0, 32'hA0, 1'b0, 32'd0, 32'hC0DE_00A0, 1'b0, 5, "fetch_wait");
    check("hold_d_rdata", d_rdata, 32'hC0DE_0090);
    tick();

    // Contention with both requests held: D,D,D,D,I,D,D,D,D,I
    mem_lat = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push_exp(1'b0, 32'hC0DE_1000, 1'b0);
      else push_exp(1'b1, 32'hC0DE_2000, 1'b0);
    end
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'd0;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (if_ready === 1'b1 || d_ready === 1'b1) n++;
    end
    if_req = 1'b0; d_req = 1'b0;
    check("contention_count", 32'(n), 32'd10);
    tick();
    check("contention_idle", 32'(mem_valid), 32'd0);
    check("contention_queue", 32'(exp_q.size()), 32'd0);
    tick();

    // Timeout on a load, then a normal fetch
    mem_lat = -1;
    run_xact(1'b1, 32'h300, 1'b0, 32'd0, 32'd0, 1'b1, TO_CYC + 1, "timeout");
    tick();
    check("timeout_err_clear", 32'(err), 32'd0);
    mem_lat = 0;
    run_xact(1'b0, 32'h14, 1'b0, 32'd0, 32'hC0DE_0014, 1'b0, 2, "after_timeout");
    tick();

    // Reset in the middle of a fetch access
    mem_lat = -1;
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    check("rstmid_busy", 32'(mem_valid), 32'd1);
    reset = 1'b0;
    tick();
    check("rstmid_mem_valid", 32'(mem_valid), 32'd0);
    check("rstmid_if_ready", 32'(if_ready), 32'd0);
    check("rstmid_mem_addr", mem_addr, 32'd0);
    reset = 1'b1;
    mem_lat = 0;
    run_xact(1'b0, 32'h40, 1'b0, 32'd0, 32'hC0DE_0040, 1'b0, 2, "rst_regrant");

    repeat (3) tick();
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
